gpr_writeback: RTL

//   Write side of the GeneralPurposeRegisters port: merges single-cycle ALU

---
 rtl/gpr_wb_pkg.sv | 11 +
 rtl/gpr_writeback_wb_fifo.sv | 40 ++++
 rtl/gpr_writeback.sv | 72 +++++++
 3 files changed

// File: rtl/gpr_wb_pkg.sv
// gpr_wb_pkg: shared widths, zero-register constant and write-back entry type
package gpr_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/gpr_writeback_wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries with count/full/empty status
module wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output wb_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= (do_push && !do_pop) ? count + 1'b1 : (!do_push && do_pop) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gpr_writeback.sv
// gpr_writeback: arbitrates ALU and long-latency results into one registered GPR write per cycle
module gpr_writeback
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [REG_DATA_W-1:0] alu_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_addr,
  input  logic [REG_DATA_W-1:0] ll_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic                  alu_stall,
  output logic                  gp_we,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [REG_DATA_W-1:0] write_data,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  err_drop
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
  wb_entry_t head, sel;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, push, sel_fifo, sel_alu, alu_busy, starve_hit;
  logic [SW-1:0] starve;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  assign ll_ready = count < ($clog2(DEPTH)+1)'(DEPTH);
  assign push = ll_valid && !full;
  assign sel_fifo = !empty && (alu_stall || !alu_valid);
  assign sel_alu = alu_valid && !alu_stall;
  assign alu_busy = sel_alu && !empty;
  assign starve_hit = alu_busy && starve == STARVE_LAST;
  assign sel = sel_fifo ? head : wb_entry_t'({alu_addr, alu_data});
  assign set_mask = (iss_valid && iss_addr != REG_ZERO) ? NUM_REGS'(1) << iss_addr : '0;
  assign clr_mask = sel_fifo ? NUM_REGS'(1) << head.addr : '0;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wb_entry_t'({ll_addr, ll_data})),
    .pop   (sel_fifo),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gp_we <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      pending <= '0;
      alu_stall <= 1'b0;
      err_drop <= 1'b0;
      starve <= '0;
    end else begin
      gp_we <= (sel_fifo || sel_alu) && sel.addr != REG_ZERO;
      write_addr <= (sel_fifo || sel_alu) ? sel.addr : write_addr;
      write_data <= (sel_fifo || sel_alu) ? sel.data : write_data;
      pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
      err_drop <= err_drop || (alu_valid && alu_stall);
      alu_stall <= starve_hit;
      starve <= (alu_busy && !starve_hit) ? starve + 1'b1 : '0;
    end
  end
endmodule
